axis_tx_arbiter: RTL

Packet-level arbiter that shares the single UART transmit byte stream between two AXI-Stream sources: the Wishbone bridge response path and a second reporter such as an async status/event source. It sits between those sources and the UART transmitter's AXIS input, on the 72 MHz PLL clock domain. It grants one source at a time for a whole packet (through `tlast`) with round-robin fairness, so bytes from different packets never interleave. An idle-timeout guard reclaims the grant from a source that stalls mid-packet.

---
 rtl/axis_tx_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/axis_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : axis_tx_arbiter
// Description : Packet-level round-robin arbiter that merges two AXI-Stream
//               byte sources into the single UART transmit stream. A source
//               keeps the grant for a whole packet (through tlast), so bytes
//               from different packets never interleave. A granted source
//               that leaves tvalid low mid-packet for IDLE_TIMEOUT cycles
//               loses its grant, and o_abort pulses.
//
// Ports       : i_clk, i_rst           clock, synchronous active-high reset
//               s0_axis_*              source 0 (bridge responses)
//               s1_axis_*              source 1 (status/event reporter)
//               m_axis_*               registered output to UART transmitter
//               o_grant                one-hot current grant, 00 when idle
//               o_abort                one-cycle pulse on timeout revocation
//
// Revision    : 1.0 - initial release
// ============================================================================
module axis_tx_arbiter #(
    parameter int DATA_WIDTH   = 8,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst,

    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic                  s0_axis_tvalid,
    input  logic                  s0_axis_tlast,
    output logic                  s0_axis_tready,

    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic                  s1_axis_tvalid,
    input  logic                  s1_axis_tlast,
    output logic                  s1_axis_tready,

    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    input  logic                  m_axis_tready,

    output logic [1:0]            o_grant,
    output logic                  o_abort
);

    localparam int                 c_CNT_W   = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT = c_CNT_W'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t                  r_state;
    logic                    r_last;      // index of most recently granted source
    logic [c_CNT_W-1:0]      r_cnt;       // idle cycles of the granted source
    logic [DATA_WIDTH-1:0]   r_m_tdata;
    logic                    r_m_tvalid;
    logic                    r_m_tlast;
    logic                    r_abort;

    logic                    w_pipe_ready;
    logic                    w_granted;
    logic                    w_sel_valid;
    logic                    w_sel_last;
    logic [DATA_WIDTH-1:0]   w_sel_data;
    logic                    w_accept;
    logic [c_CNT_W-1:0]      w_cnt_inc;

    // The single output register can take a new beat when it is empty or
    // is being drained this cycle.
    assign w_pipe_ready = !r_m_tvalid || m_axis_tready;
    assign w_granted    = (r_state == ST_GNT0) || (r_state == ST_GNT1);

    // Source mux; only meaningful while a grant is held.
    assign w_sel_valid  = (r_state == ST_GNT1) ? s1_axis_tvalid : s0_axis_tvalid;
    assign w_sel_last   = (r_state == ST_GNT1) ? s1_axis_tlast  : s0_axis_tlast;
    assign w_sel_data   = (r_state == ST_GNT1) ? s1_axis_tdata  : s0_axis_tdata;

    assign w_accept     = w_granted && w_sel_valid && w_pipe_ready;
    assign w_cnt_inc    = r_cnt + c_CNT_W'(1);

    assign s0_axis_tready = (r_state == ST_GNT0) && w_pipe_ready;
    assign s1_axis_tready = (r_state == ST_GNT1) && w_pipe_ready;

    assign m_axis_tdata  = r_m_tdata;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tlast  = r_m_tlast;
    assign o_grant       = {r_state == ST_GNT1, r_state == ST_GNT0};
    assign o_abort       = r_abort;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_cnt      <= '0;
            r_m_tdata  <= '0;
            r_m_tvalid <= 1'b0;
            r_m_tlast  <= 1'b0;
            r_abort    <= 1'b0;
        end else begin
            r_abort <= 1'b0;

            // Output register: load on acceptance, otherwise drain.
            if (w_accept) begin
                r_m_tdata  <= w_sel_data;
                r_m_tlast  <= w_sel_last;
                r_m_tvalid <= 1'b1;
            end else if (m_axis_tready) begin
                r_m_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // On a tie, the source that was not granted last wins.
                    if (s0_axis_tvalid && (!s1_axis_tvalid || r_last)) begin
                        r_state <= ST_GNT0;
                        r_last  <= 1'b0;
                        r_cnt   <= '0;
                    end else if (s1_axis_tvalid) begin
                        r_state <= ST_GNT1;
                        r_last  <= 1'b1;
                        r_cnt   <= '0;
                    end
                end

                ST_GNT0, ST_GNT1: begin
                    if (w_accept) begin
                        // A tlast acceptance ends the packet normally and
                        // pre-empts any timeout on the same cycle.
                        r_cnt <= '0;
                        if (w_sel_last) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (!w_sel_valid) begin
                        // A stalled output with valid held high is not idle;
                        // only an absent tvalid counts toward the timeout.
                        if (w_cnt_inc == c_TIMEOUT) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_abort <= 1'b1;
                        end else if (r_cnt != c_TIMEOUT) begin
                            r_cnt <= w_cnt_inc;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
